i2c_slave_ctrl: RTL and testbench
=================================

I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

Interface
REQ-001 SHALL provide parameter SLV_ADDR, default 7'h50, 7-bit slave address this block answers to.
REQ-002 SHALL provide port sample_clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port scl_i  input  1  bus SCL, already synchronized to sample_clk.
REQ-005 SHALL provide port sda_i  input  1  bus SDA, already synchronized to sample_clk.
REQ-006 SHALL provide port start_det  input  1  START pulse from start/stop detector.
REQ-007 SHALL provide port stop_det  input  1  STOP pulse from start/stop detector.
REQ-008 SHALL provide port det_en  output  1  detector enable; equals registered SCL (scl_q).
REQ-009 SHALL provide port sda_oe  output  1  1 = pull SDA low; 0 = release.
REQ-010 SHALL provide port wr_valid  output  1  one-cycle strobe, received data byte valid.
REQ-011 SHALL provide port wr_data  output  8  last received data byte.
REQ-012 SHALL provide port rd_req  output  1  one-cycle strobe requesting next transmit byte.
REQ-013 SHALL provide port rd_data  input  8  transmit byte from user logic.
REQ-014 SHALL provide port busy  output  1  1 whenever state != IDLE.

Function
REQ-015 SHALL register scl_i into scl_q each cycle; scl_rise = scl_i & ~scl_q, scl_fall = ~scl_i & scl_q.
REQ-016 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK; IDLE ignores everything except start_det.
REQ-017 SHALL, on start_det in any state (repeated START included), go to ADDR next cycle, clear 3-bit bit_cnt and 8-bit shift register, drive sda_oe=0.
REQ-018 SHALL, on stop_det in any state, go to IDLE next cycle with sda_oe=0; start_det wins if both assert in the same cycle.
REQ-019 SHALL, in ADDR and WR_BYTE, shift sda_i into shreg LSB (MSB-first byte) on each scl_rise and increment bit_cnt, wrapping 7->0.
REQ-020 SHALL, on 8th ADDR scl_rise, compare shreg[7:1] to SLV_ADDR and latch shreg[0] as rw; mismatch -> IDLE, no ACK, no strobes.
REQ-021 SHALL, on match, enter ADDR_ACK at the next scl_fall and assert sda_oe=1 that same cycle; if rw=1, pulse rd_req that cycle.
REQ-022 SHALL, at the scl_fall ending ADDR_ACK, go to WR_BYTE (rw=0, sda_oe=0) or RD_BYTE (rw=1, shreg<=rd_data, sda_oe=~rd_data[7]).
REQ-023 SHALL, on 8th WR_BYTE scl_rise, set wr_data to the received byte and pulse wr_valid one cycle that cycle's next edge.
REQ-024 SHALL enter WR_ACK at the following scl_fall with sda_oe=1; at the next scl_fall release sda_oe, clear bit_cnt, return to WR_BYTE.
REQ-025 SHALL, in RD_BYTE, shift shreg left and drive sda_oe=~shreg[6] on each scl_fall after the first bit; after the 8th bit's scl_fall go to RD_ACK with sda_oe=0.
REQ-026 SHALL, in RD_ACK, sample sda_i on scl_rise: 0 (ACK) -> pulse rd_req, then at next scl_fall load rd_data, drive MSB, enter RD_BYTE; 1 (NACK) -> IDLE, sda_oe=0.
REQ-027 SHALL require rd_data stable from the cycle after rd_req until the next scl_fall; it is sampled only at that fall.
REQ-028 SHALL never assert wr_valid and rd_req in the same cycle; each is high for exactly one cycle per byte.
REQ-029 SHALL keep bit_cnt 3 bits and hold wr_data between strobes.

Reset
REQ-030 SHALL, while rst=1, asynchronously force state=IDLE, scl_q=1, bit_cnt=0, shreg=0, rw=0, sda_oe=0, wr_valid=0, wr_data=8'h00, rd_req=0, busy=0.
REQ-031 SHALL, on rst assertion mid-transfer, release SDA immediately and after deassertion ignore the bus until the next start_det.

Verification
REQ-032 SHALL cover write: START, addr 0xA0 (0x50,W), byte 0x3C, STOP -> ACK low on both 9th clocks, one wr_valid with wr_data=0x3C, busy 0 after STOP.
REQ-033 SHALL cover address miss: START, addr 0xA2 -> sda_oe stays 0, no strobes, state IDLE after 8th rise.
REQ-034 SHALL cover read: START, addr 0xA1, rd_data=0x96 then 0x5A, master ACK then NACK -> SDA bits 10010110, 01011010; rd_req pulses twice.
REQ-035 SHALL cover repeated START after one write byte, then addr 0xA1 -> returns to ADDR, read path entered, no extra wr_valid.
REQ-036 SHALL cover rst=1 while sda_oe=1 in WR_ACK -> sda_oe=0 same cycle, all outputs at reset values; later STOP without START produces no activity.

Source files
------------

// File: rtl/i2c_slave_ctrl_if.sv
// Bus-side and user-side signals of the I2C slave controller, bundled so the
// controller and its environment connect through one port.
interface i2c_slave_ctrl_if;
  logic       scl_i;
  logic       sda_i;
  logic       start_det;
  logic       stop_det;
  logic       det_en;
  logic       sda_oe;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       busy;

  modport slave (
    input  scl_i, sda_i, start_det, stop_det, rd_data,
    output det_en, sda_oe, wr_valid, wr_data, rd_req, busy
  );

  modport master (
    output scl_i, sda_i, start_det, stop_det, rd_data,
    input  det_en, sda_oe, wr_valid, wr_data, rd_req, busy
  );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// I2C slave byte engine: matches a 7-bit address, receives write bytes and
// serves read bytes. START/STOP come from an external detector.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLV_ADDR = 7'h50
) (
  input  logic             sample_clk,
  input  logic             rst,
  i2c_slave_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_BYTE  = 3'd3,
    WR_ACK   = 3'd4,
    RD_BYTE  = 3'd5,
    RD_ACK   = 3'd6
  } state_t;

  state_t     state_r,    state_nxt_s;
  logic       scl_q_r;
  logic [2:0] bit_cnt_r,  bit_cnt_nxt_s;
  logic [7:0] shreg_r,    shreg_nxt_s;
  logic       rw_r,       rw_nxt_s;
  logic       pend_r,     pend_nxt_s;
  logic       sda_oe_r,   sda_oe_nxt_s;
  logic       wr_valid_r, wr_valid_nxt_s;
  logic [7:0] wr_data_r,  wr_data_nxt_s;
  logic       rd_req_r,   rd_req_nxt_s;
  logic       busy_r,     busy_nxt_s;

  logic       scl_rise_s;
  logic       scl_fall_s;
  logic       last_bit_s;
  logic [7:0] shreg_shl_s;
  logic [7:0] byte_in_s;

  // Append one received bit to a left-shifted byte (MSB first on the wire).
  function automatic logic [7:0] shift_in(input logic [7:0] shifted, input logic bit_in);
    shift_in = shifted | {7'b000_0000, bit_in};
  endfunction

  assign scl_rise_s  = bus.scl_i & ~scl_q_r;
  assign scl_fall_s  = ~bus.scl_i & scl_q_r;
  assign last_bit_s  = (bit_cnt_r == 3'd7);
  assign shreg_shl_s = shreg_r << 1;
  assign byte_in_s   = shift_in(shreg_shl_s, bus.sda_i);

  // pend_r marks "byte finished on SCL rise, act on the following SCL fall".
  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s    = state_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    shreg_nxt_s    = shreg_r;
    rw_nxt_s       = rw_r;
    pend_nxt_s     = pend_r;
    sda_oe_nxt_s   = sda_oe_r;
    wr_valid_nxt_s = 1'b0;
    wr_data_nxt_s  = wr_data_r;
    rd_req_nxt_s   = 1'b0;

    if (bus.start_det) begin
      state_nxt_s   = ADDR;
      bit_cnt_nxt_s = 3'd0;
      shreg_nxt_s   = 8'h00;
      pend_nxt_s    = 1'b0;
      sda_oe_nxt_s  = 1'b0;
    end else if (bus.stop_det) begin
      state_nxt_s  = IDLE;
      pend_nxt_s   = 1'b0;
      sda_oe_nxt_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          pend_nxt_s   = 1'b0;
          sda_oe_nxt_s = 1'b0;
        end

        ADDR: begin
          if (scl_rise_s) begin
            shreg_nxt_s   = byte_in_s;
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            if (last_bit_s && (byte_in_s[7:1] == SLV_ADDR)) begin
              rw_nxt_s   = byte_in_s[0];
              pend_nxt_s = 1'b1;
            end else if (last_bit_s) begin
              state_nxt_s = IDLE;
            end else begin
              pend_nxt_s = 1'b0;
            end
          end else if (scl_fall_s && pend_r) begin
            state_nxt_s  = ADDR_ACK;
            pend_nxt_s   = 1'b0;
            sda_oe_nxt_s = 1'b1;
            rd_req_nxt_s = rw_r;
          end else begin
            pend_nxt_s = pend_r;
          end
        end

        ADDR_ACK: begin
          if (scl_fall_s && rw_r) begin
            state_nxt_s   = RD_BYTE;
            bit_cnt_nxt_s = 3'd0;
            shreg_nxt_s   = bus.rd_data;
            sda_oe_nxt_s  = ~bus.rd_data[7];
          end else if (scl_fall_s) begin
            state_nxt_s   = WR_BYTE;
            bit_cnt_nxt_s = 3'd0;
            sda_oe_nxt_s  = 1'b0;
          end else begin
            sda_oe_nxt_s = 1'b1;
          end
        end

        WR_BYTE: begin
          if (scl_rise_s) begin
            shreg_nxt_s   = byte_in_s;
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            if (last_bit_s) begin
              wr_data_nxt_s  = byte_in_s;
              wr_valid_nxt_s = 1'b1;
              pend_nxt_s     = 1'b1;
            end else begin
              pend_nxt_s = 1'b0;
            end
          end else if (scl_fall_s && pend_r) begin
            state_nxt_s  = WR_ACK;
            pend_nxt_s   = 1'b0;
            sda_oe_nxt_s = 1'b1;
          end else begin
            pend_nxt_s = pend_r;
          end
        end

        WR_ACK: begin
          if (scl_fall_s) begin
            state_nxt_s   = WR_BYTE;
            bit_cnt_nxt_s = 3'd0;
            sda_oe_nxt_s  = 1'b0;
          end else begin
            sda_oe_nxt_s = 1'b1;
          end
        end

        RD_BYTE: begin
          if (scl_fall_s && last_bit_s) begin
            state_nxt_s   = RD_ACK;
            bit_cnt_nxt_s = 3'd0;
            pend_nxt_s    = 1'b0;
            sda_oe_nxt_s  = 1'b0;
          end else if (scl_fall_s) begin
            shreg_nxt_s   = shreg_shl_s;
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            sda_oe_nxt_s  = ~shreg_r[6];
          end else begin
            sda_oe_nxt_s = sda_oe_r;
          end
        end

        RD_ACK: begin
          // Master drives the ACK slot; a released line (NACK) ends the read.
          if (scl_rise_s && !pend_r && !bus.sda_i) begin
            rd_req_nxt_s = 1'b1;
            pend_nxt_s   = 1'b1;
          end else if (scl_rise_s && !pend_r) begin
            state_nxt_s  = IDLE;
            sda_oe_nxt_s = 1'b0;
          end else if (scl_fall_s && pend_r) begin
            state_nxt_s   = RD_BYTE;
            pend_nxt_s    = 1'b0;
            bit_cnt_nxt_s = 3'd0;
            shreg_nxt_s   = bus.rd_data;
            sda_oe_nxt_s  = ~bus.rd_data[7];
          end else begin
            sda_oe_nxt_s = 1'b0;
          end
        end

        default: begin
          state_nxt_s  = IDLE;
          pend_nxt_s   = 1'b0;
          sda_oe_nxt_s = 1'b0;
        end
      endcase
    end

    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State and output registers; reset releases SDA immediately.
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      scl_q_r    <= 1'b1;
      bit_cnt_r  <= 3'd0;
      shreg_r    <= 8'h00;
      rw_r       <= 1'b0;
      pend_r     <= 1'b0;
      sda_oe_r   <= 1'b0;
      wr_valid_r <= 1'b0;
      wr_data_r  <= 8'h00;
      rd_req_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      scl_q_r    <= bus.scl_i;
      bit_cnt_r  <= bit_cnt_nxt_s;
      shreg_r    <= shreg_nxt_s;
      rw_r       <= rw_nxt_s;
      pend_r     <= pend_nxt_s;
      sda_oe_r   <= sda_oe_nxt_s;
      wr_valid_r <= wr_valid_nxt_s;
      wr_data_r  <= wr_data_nxt_s;
      rd_req_r   <= rd_req_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  assign bus.det_en   = scl_q_r;
  assign bus.sda_oe   = sda_oe_r;
  assign bus.wr_valid = wr_valid_r;
  assign bus.wr_data  = wr_data_r;
  assign bus.rd_req   = rd_req_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: a bit-level I2C master with a transaction-level
// model; strobes are checked by a scoreboard monitor.
module tb_i2c_slave_ctrl;
  localparam int         HALF    = 4;
  localparam logic [6:0] TB_ADDR = 7'h50;

  logic sample_clk = 1'b0;
  logic rst        = 1'b1;
  logic sda_m      = 1'b1;
  logic [7:0] rd_data_v = 8'h00;

  i2c_slave_ctrl_if bus();

  i2c_slave_ctrl #(.SLV_ADDR(TB_ADDR)) dut (
    .sample_clk (sample_clk),
    .rst        (rst),
    .bus        (bus)
  );

  always #5 sample_clk = ~sample_clk;

  assign bus.sda_i   = sda_m & ~bus.sda_oe;
  assign bus.rd_data = rd_data_v;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] wr_exp[$];
  logic [7:0] rd_exp[$];
  logic [7:0] payload[$];
  logic wr_valid_d = 1'b0;
  logic rd_req_d   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sample_clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; cyc(HALF);
    bus.scl_i = 1'b1; cyc(HALF);
    sda_m = 1'b0; bus.start_det = 1'b1; cyc(1);
    bus.start_det = 1'b0; cyc(HALF);
    bus.scl_i = 1'b0; cyc(HALF);
  endtask

  task automatic bus_stop();
    bus.scl_i = 1'b0; sda_m = 1'b0; cyc(HALF);
    bus.scl_i = 1'b1; cyc(HALF);
    sda_m = 1'b1; bus.stop_det = 1'b1; cyc(1);
    bus.stop_det = 1'b0; cyc(HALF);
  endtask

  // One SCL clock: master drives b (1 = release) and samples the line mid-high.
  task automatic clock_bit(input logic b, output logic line);
    sda_m = b; cyc(HALF);
    bus.scl_i = 1'b1; cyc(HALF / 2);
    line = bus.sda_i; cyc(HALF / 2);
    bus.scl_i = 1'b0; cyc(1);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_line);
    logic dummy;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], dummy);
    clock_bit(1'b1, ack_line);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic dummy;
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, b[i]);
    clock_bit(nack, dummy);
  endtask

  // Transaction-level model: a matching address is ACKed, written bytes each
  // produce one wr_valid, read bytes appear on SDA in order, last read is NACKed.
  task automatic xfer(input logic [7:0] addr, input logic do_stop);
    logic       matched;
    logic       ack;
    logic [7:0] got;
    matched = (addr[7:1] == TB_ADDR);
    if (matched && addr[0]) foreach (payload[k]) rd_exp.push_back(payload[k]);
    bus_start();
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    send_byte(addr, ack);
    check("addr_ack", {31'd0, ack}, matched ? 32'd0 : 32'd1);
    if (!matched) begin
      check("miss_idle", {31'd0, bus.busy}, 32'd0);
    end else if (!addr[0]) begin
      foreach (payload[k]) begin
        wr_exp.push_back(payload[k]);
        send_byte(payload[k], ack);
        check("wr_ack", {31'd0, ack}, 32'd0);
      end
    end else begin
      foreach (payload[k]) begin
        recv_byte(k == payload.size() - 1, got);
        check("rd_byte", {24'd0, got}, {24'd0, payload[k]});
      end
    end
    if (do_stop) begin
      bus_stop();
      check("busy_after_stop", {31'd0, bus.busy}, 32'd0);
      check("sda_released", {31'd0, bus.sda_oe}, 32'd0);
    end
  endtask

  // Scoreboard monitor: every strobe must match a queued expectation.
  always @(negedge sample_clk) begin
    if (bus.wr_valid) begin
      check("wr_rd_exclusive", {31'd0, bus.rd_req}, 32'd0);
      check("wr_valid_width", {31'd0, wr_valid_d}, 32'd0);
      if (wr_exp.size() == 0) check("wr_valid_unexpected", {31'd0, bus.wr_valid}, 32'd0);
      else check("wr_data", {24'd0, bus.wr_data}, {24'd0, wr_exp.pop_front()});
    end
    if (bus.rd_req) begin
      check("rd_req_width", {31'd0, rd_req_d}, 32'd0);
      if (rd_exp.size() == 0) check("rd_req_unexpected", {31'd0, bus.rd_req}, 32'd0);
      else rd_data_v = rd_exp.pop_front();
    end
    wr_valid_d = bus.wr_valid;
    rd_req_d   = bus.rd_req;
  end

  initial begin
    logic ack;
    logic dummy;
    logic [7:0] a;
    bus.scl_i     = 1'b1;
    bus.start_det = 1'b0;
    bus.stop_det  = 1'b0;
    cyc(3);
    check("rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_wr_data", {24'd0, bus.wr_data}, 32'd0);
    check("rst_det_en", {31'd0, bus.det_en}, 32'd1);
    rst = 1'b0;
    cyc(3);

    payload.delete(); payload.push_back(8'h3C);
    xfer(8'hA0, 1'b1);
    check("wr_data_hold", {24'd0, bus.wr_data}, 32'h3C);

    payload.delete();
    xfer(8'hA2, 1'b1);

    payload.delete(); payload.push_back(8'h96); payload.push_back(8'h5A);
    xfer(8'hA1, 1'b1);

    payload.delete(); payload.push_back(8'h11);
    xfer(8'hA0, 1'b0);
    payload.delete(); payload.push_back(8'hC5);
    xfer(8'hA1, 1'b1);

    // Reset while the slave is ACKing a written byte.
    bus_start();
    send_byte(8'hA0, ack);
    check("rst_case_addr_ack", {31'd0, ack}, 32'd0);
    wr_exp.push_back(8'hE7);
    for (int i = 7; i >= 0; i--) clock_bit(a_bit(8'hE7, i), dummy);
    cyc(1);
    check("wr_ack_oe", {31'd0, bus.sda_oe}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
    check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("async_rst_wr_data", {24'd0, bus.wr_data}, 32'd0);
    check("async_rst_wr_valid", {31'd0, bus.wr_valid}, 32'd0);
    check("async_rst_rd_req", {31'd0, bus.rd_req}, 32'd0);
    check("async_rst_det_en", {31'd0, bus.det_en}, 32'd1);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    bus_stop();
    check("stop_no_start_busy", {31'd0, bus.busy}, 32'd0);
    send_byte(8'hA0, ack);
    check("no_start_ignored", {31'd0, ack}, 32'd1);
    check("no_start_busy", {31'd0, bus.busy}, 32'd0);
    bus_stop();

    for (int t = 0; t < 16; t++) begin
      case ($urandom_range(0, 3))
        0:       a = 8'hA0;
        1:       a = 8'hA1;
        2:       a = 8'($urandom);
        default: a = 8'hA1;
      endcase
      payload.delete();
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) payload.push_back(8'($urandom));
      xfer(a, 1'b1);
    end

    cyc(4);
    check("wr_exp_drained", wr_exp.size(), 32'd0);
    check("rd_exp_drained", rd_exp.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  function automatic logic a_bit(input logic [7:0] v, input int i);
    a_bit = v[i];
  endfunction

endmodule
